ntr_cmd_capture: RTL

// - Captures cartridge-bus (NTR) command packets in the system clk domain. Generalises the

---
 rtl/ntr_pkg.sv | 13 +
 rtl/ntr_sync.sv | 24 ++
 rtl/ntr_cmd_capture.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ntr_pkg.sv
// Shared definitions for the NTR cartridge-bus command capture path.
package ntr_pkg;

    localparam int NTR_CMD_BYTES = 8;
    localparam int NTR_DATA_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } ntr_state_e;

endpackage

// File: rtl/ntr_sync.sv
// Multi-flop synchroniser with a per-bit reset value; all bits share one chain so they stay aligned.
module ntr_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chain <= {STAGES{RST_VAL}};
        else
            chain <= {chain[STAGES-2:0], din};
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/ntr_cmd_capture.sv
// Captures NTR command packets: synchronises the async bus, detects ntr_clk rising edges,
// frames on chip select, and counts data-phase beats after each complete command.
module ntr_cmd_capture
    import ntr_pkg::*;
#(
    parameter int DATA_W      = NTR_DATA_W,
    parameter int CMD_BYTES   = NTR_CMD_BYTES,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ntr_clk,
    input  logic                        ntr_cs_n,
    input  logic [DATA_W-1:0]           ntr_data,
    output logic [CMD_BYTES*DATA_W-1:0] cmd,
    output logic                        cmd_valid,
    output logic                        cmd_abort,
    output logic                        busy,
    output logic [CNT_W-1:0]            data_cnt
);

    localparam int CMD_W  = CMD_BYTES * DATA_W;
    localparam int HIST_W = (CMD_BYTES > 1) ? (CMD_BYTES - 1) * DATA_W : 1;
    localparam int BEAT_W = $clog2(CMD_BYTES + 1);
    localparam logic [DATA_W+1:0] SYNC_RST = {2'b11, {DATA_W{1'b0}}};

    logic              sync_clk, sync_cs_n;
    logic [DATA_W-1:0] sync_data;
    logic              sync_clk_q;
    logic              bus_edge;

    ntr_state_e        state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [HIST_W-1:0] hist, hist_nxt;
    logic [CMD_W-1:0]  shifted;
    logic [CMD_W-1:0]  cmd_nxt;
    logic              valid_nxt, abort_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    ntr_sync #(
        .WIDTH   (DATA_W + 2),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SYNC_RST)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({ntr_clk, ntr_cs_n, ntr_data}),
        .dout  ({sync_clk, sync_cs_n, sync_data})
    );

    assign bus_edge = sync_clk & ~sync_clk_q;

    // hist holds the beats already taken; the newest beat lands in the LSBs
    generate
        if (CMD_BYTES > 1) begin : g_multi
            assign shifted = {hist, sync_data};
        end else begin : g_single
            assign shifted = sync_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat       <= '0;
            hist       <= '0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            cmd_abort  <= 1'b0;
            data_cnt   <= '0;
            sync_clk_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            hist       <= hist_nxt;
            cmd        <= cmd_nxt;
            cmd_valid  <= valid_nxt;
            cmd_abort  <= abort_nxt;
            data_cnt   <= cnt_nxt;
            sync_clk_q <= sync_clk;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        hist_nxt  = hist;
        cmd_nxt   = cmd;
        valid_nxt = 1'b0;
        abort_nxt = 1'b0;
        cnt_nxt   = data_cnt;
        case (state)
            ST_IDLE: begin
                if (!sync_cs_n) begin
                    state_nxt = ST_CMD;
                    beat_nxt  = '0;
                end
            end
            ST_CMD: begin
                // chip select release takes priority over a coincident edge
                if (sync_cs_n) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (bus_edge) begin
                    hist_nxt = shifted[HIST_W-1:0];
                    beat_nxt = beat + 1'b1;
                    if (beat == BEAT_W'(CMD_BYTES - 1)) begin
                        cmd_nxt   = shifted;
                        valid_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sync_cs_n)
                    state_nxt = ST_IDLE;
                else if (bus_edge && data_cnt != {CNT_W{1'b1}})
                    cnt_nxt = data_cnt + 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule
